lock_ctrl: RTL and testbench



---
 rtl/lock_pkg.sv | 26 ++
 rtl/lock_wdog.sv | 30 +++
 rtl/lock_ctrl.sv | 156 +++++++++++++++
 tb/tb_lock_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared encodings for the canal-lock chamber sequencer.
package lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_OPEN_IN   = 3'd2,
        S_CLOSE_IN  = 3'd3,
        S_XFER      = 3'd4,
        S_OPEN_OUT  = 3'd5,
        S_CLOSE_OUT = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [1:0] TSEL_GATE  = 2'd0;
    localparam logic [1:0] TSEL_FILL  = 2'd1;
    localparam logic [1:0] TSEL_DRAIN = 2'd2;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [1:0] valve_sel(input logic to_high);
        return to_high ? TSEL_FILL : TSEL_DRAIN;
    endfunction

endpackage

// File: rtl/lock_wdog.sv
// Watchdog for timed states: counts cycles spent in the state.
module lock_wdog #(
    parameter int unsigned WD_CYCLES = 1024,
    parameter int unsigned WD_W      = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WD_W-1:0] LIM = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] cnt;

    // clr marks the first cycle of a state, which already counts as one
    assign expire = en && !clr && (cnt >= LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= WD_W'(1);
        end else if (en && !expire) begin
            cnt <= cnt + WD_W'(1);
        end
    end

endmodule

// File: rtl/lock_ctrl.sv
// Canal-lock chamber sequencer: gates, valves, level tracking and
// chamber-timer handshake with a watchdog on every timed wait.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned WD_CYCLES = 1024,
    parameter int unsigned WD_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       dir,
    input  logic       boat_in,
    input  logic       boat_out,
    input  logic       tmr_done,
    output logic       tmr_set,
    output logic [1:0] tmr_sel,
    output logic       gate_lo_open,
    output logic       gate_hi_open,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       level_hi,
    output logic       busy,
    output logic       fault
);

    state_t state;
    logic   dir_q;
    logic   timed;
    logic   tdone;
    logic   wd_exp;

    assign timed = (state == S_PRE) || (state == S_CLOSE_IN) ||
                   (state == S_XFER) || (state == S_CLOSE_OUT);

    // done may be stale during the set cycle
    assign tdone = timed && !tmr_set && tmr_done;

    lock_wdog #(
        .WD_CYCLES (WD_CYCLES),
        .WD_W      (WD_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_set),
        .en     (timed),
        .expire (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dir_q        <= DIR_UP;
            tmr_set      <= 1'b0;
            tmr_sel      <= TSEL_GATE;
            gate_lo_open <= 1'b0;
            gate_hi_open <= 1'b0;
            fill_valve   <= 1'b0;
            drain_valve  <= 1'b0;
            level_hi     <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            tmr_set <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        dir_q <= dir;
                        busy  <= 1'b1;
                        if (level_hi == dir) begin
                            state        <= S_OPEN_IN;
                            gate_lo_open <= (dir == DIR_UP);
                            gate_hi_open <= (dir == DIR_DOWN);
                        end else begin
                            state       <= S_PRE;
                            tmr_set     <= 1'b1;
                            tmr_sel     <= valve_sel(dir);
                            fill_valve  <= dir;
                            drain_valve <= !dir;
                        end
                    end
                end
                S_PRE: begin
                    if (tdone) begin
                        state        <= S_OPEN_IN;
                        fill_valve   <= 1'b0;
                        drain_valve  <= 1'b0;
                        level_hi     <= !level_hi;
                        gate_lo_open <= (dir_q == DIR_UP);
                        gate_hi_open <= (dir_q == DIR_DOWN);
                    end
                end
                S_OPEN_IN: begin
                    if (boat_in) begin
                        state        <= S_CLOSE_IN;
                        gate_lo_open <= 1'b0;
                        gate_hi_open <= 1'b0;
                        tmr_set      <= 1'b1;
                        tmr_sel      <= TSEL_GATE;
                    end
                end
                S_CLOSE_IN: begin
                    if (tdone) begin
                        state       <= S_XFER;
                        tmr_set     <= 1'b1;
                        tmr_sel     <= valve_sel(!dir_q);
                        fill_valve  <= !dir_q;
                        drain_valve <= dir_q;
                    end
                end
                S_XFER: begin
                    if (tdone) begin
                        state        <= S_OPEN_OUT;
                        fill_valve   <= 1'b0;
                        drain_valve  <= 1'b0;
                        level_hi     <= !level_hi;
                        gate_hi_open <= (dir_q == DIR_UP);
                        gate_lo_open <= (dir_q == DIR_DOWN);
                    end
                end
                S_OPEN_OUT: begin
                    if (boat_out) begin
                        state        <= S_CLOSE_OUT;
                        gate_lo_open <= 1'b0;
                        gate_hi_open <= 1'b0;
                        tmr_set      <= 1'b1;
                        tmr_sel      <= TSEL_GATE;
                    end
                end
                S_CLOSE_OUT: begin
                    if (tdone) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        tmr_sel <= TSEL_GATE;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
            endcase

            // expiry loses to a same-cycle done
            if (wd_exp && !tdone) begin
                state        <= S_FAULT;
                tmr_set      <= 1'b0;
                gate_lo_open <= 1'b0;
                gate_hi_open <= 1'b0;
                fill_valve   <= 1'b0;
                drain_valve  <= 1'b0;
                busy         <= 1'b1;
                fault        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl with a 5-cycle chamber timer model.
module tb_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, dir, boat_in, boat_out;
    logic       tmr_done;
    logic       tmr_set;
    logic [1:0] tmr_sel;
    logic       gate_lo_open, gate_hi_open;
    logic       fill_valve, drain_valve;
    logic       level_hi, busy, fault;

    logic       mdl_done;
    logic       stale;
    logic       hang;
    int         tcnt;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] outs;

    always #5 clk = ~clk;

    lock_ctrl #(
        .WD_CYCLES (16),
        .WD_W      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .dir          (dir),
        .boat_in      (boat_in),
        .boat_out     (boat_out),
        .tmr_done     (tmr_done),
        .tmr_set      (tmr_set),
        .tmr_sel      (tmr_sel),
        .gate_lo_open (gate_lo_open),
        .gate_hi_open (gate_hi_open),
        .fill_valve   (fill_valve),
        .drain_valve  (drain_valve),
        .level_hi     (level_hi),
        .busy         (busy),
        .fault        (fault)
    );

    assign tmr_done = mdl_done | stale;
    assign outs = {gate_lo_open, gate_hi_open, fill_valve, drain_valve,
                   level_hi, busy, fault, tmr_set};

    // timer: done rises in the 5th cycle after the set cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            mdl_done <= 1'b0;
            tcnt     <= 0;
        end else if (tmr_set) begin
            mdl_done <= 1'b0;
            tcnt     <= hang ? 0 : 4;
        end else if (tcnt != 0) begin
            tcnt <= tcnt - 1;
            if (tcnt == 1) mdl_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            n_chk++;
            assert (!(gate_lo_open && gate_hi_open) &&
                    !(fill_valve && drain_valve) &&
                    !((gate_lo_open || gate_hi_open) &&
                      (fill_valve || drain_valve)))
            else begin
                n_fail++;
                $error("FAIL interlock: got %b required no overlap", outs);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %b required %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic d;
        logic ok;
        rst_n = 1'b0; req = 1'b0; dir = 1'b0;
        boat_in = 1'b0; boat_out = 1'b0;
        stale = 1'b0; hang = 1'b0;
        tick(2);
        chk("reset_outs", outs, 8'b0000_0000);
        chk("reset_sel", {6'd0, tmr_sel}, 8'd0);
        rst_n = 1'b1;
        tick(1);
        chk("idle_outs", outs, 8'b0000_0000);

        // up passage, chamber already low: PRE skipped
        req = 1'b1; dir = 1'b0;
        tick(1);
        req = 1'b0;
        chk("open_in_lo", outs, 8'b1000_0100);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("no_set_before_boat", outs, 8'b1000_0100);
        end
        stale = 1'b1;
        boat_in = 1'b1;
        tick(1);
        boat_in = 1'b0;
        chk("close_in_first", outs, 8'b0000_0101);
        chk("close_in_sel", {6'd0, tmr_sel}, 8'd0);
        tick(1);
        stale = 1'b0;
        chk("stale_ignored", outs, 8'b0000_0100);
        tick(4);
        chk("close_in_wait", outs, 8'b0000_0100);
        tick(1);
        chk("xfer_fill", outs, 8'b0010_0101);
        chk("xfer_sel", {6'd0, tmr_sel}, 8'd1);
        tick(5);
        chk("xfer_wait", outs, 8'b0010_0100);
        tick(1);
        chk("open_out_hi", outs, 8'b0100_1100);
        tick(3);
        chk("open_out_hold", outs, 8'b0100_1100);
        boat_out = 1'b1;
        tick(1);
        boat_out = 1'b0;
        chk("close_out_first", outs, 8'b0000_1101);
        tick(5);
        chk("close_out_wait", outs, 8'b0000_1100);
        tick(1);
        chk("idle_after_up", outs, 8'b0000_1000);

        // up passage from high level: PRE drains first
        req = 1'b1; dir = 1'b0;
        tick(1);
        req = 1'b0;
        chk("pre_drain", outs, 8'b0001_1101);
        chk("pre_sel", {6'd0, tmr_sel}, 8'd2);
        tick(5);
        chk("pre_wait", outs, 8'b0001_1100);
        tick(1);
        chk("pre_to_open_in", outs, 8'b1000_0100);
        boat_in = 1'b1;
        tick(1);
        boat_in = 1'b0;
        tick(6);
        chk("xfer2", outs, 8'b0010_0101);
        tick(6);
        chk("open_out2", outs, 8'b0100_1100);
        req = 1'b1; dir = 1'b1;
        tick(1);
        req = 1'b0;
        chk("req_busy_ignored", outs, 8'b0100_1100);
        boat_out = 1'b1;
        tick(1);
        boat_out = 1'b0;
        tick(6);
        chk("idle2", outs, 8'b0000_1000);
        tick(3);
        chk("no_queued_req", outs, 8'b0000_1000);

        // down passage, timer stalls in XFER -> watchdog
        req = 1'b1; dir = 1'b1;
        tick(1);
        req = 1'b0;
        chk("open_in_hi", outs, 8'b0100_1100);
        boat_in = 1'b1;
        tick(1);
        boat_in = 1'b0;
        tick(6);
        chk("xfer_drain", outs, 8'b0001_1101);
        chk("xfer_drain_sel", {6'd0, tmr_sel}, 8'd2);
        hang = 1'b1;
        tick(15);
        chk("wd_last_cycle", outs, 8'b0001_1100);
        tick(1);
        chk("wd_fault", outs, 8'b0000_1110);
        req = 1'b1;
        tick(5);
        req = 1'b0;
        chk("fault_sticky", outs, 8'b0000_1110);
        hang = 1'b0;
        rst_n = 1'b0;
        tick(1);
        chk("fault_reset", outs, 8'b0000_0000);
        rst_n = 1'b1;
        tick(1);

        // reset mid-XFER
        req = 1'b1; dir = 1'b0;
        tick(1);
        req = 1'b0;
        boat_in = 1'b1;
        tick(1);
        boat_in = 1'b0;
        tick(6);
        chk("xfer3", outs, 8'b0010_0101);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("abort_reset", outs, 8'b0000_0000);
        rst_n = 1'b1;
        tick(1);
        chk("abort_idle", outs, 8'b0000_0000);

        // random passages under the interlock monitor
        for (int p = 0; p < 200; p++) begin
            d = 1'($urandom_range(0, 1));
            dir = d; req = 1'b1;
            tick(1);
            req = 1'b0;
            ok = 1'b0;
            for (int c = 0; c < 400 && !ok; c++) begin
                boat_in  = ($urandom_range(0, 3) == 0);
                boat_out = ($urandom_range(0, 3) == 0);
                req      = ($urandom_range(0, 7) == 0);
                dir      = 1'($urandom_range(0, 1));
                tick(1);
                if (!busy) ok = 1'b1;
            end
            req = 1'b0; boat_in = 1'b0; boat_out = 1'b0;
            chk("rnd_done", {7'd0, ok}, 8'd1);
            chk("rnd_level", {7'd0, level_hi}, {7'd0, ~d});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
